bu_writeback: RTL

Write-back router for the 8-butterfly NTT/iNTT datapath. It takes the 8 butterfly-unit result pairs and applies the inverse of the read-side BRAM-to-BU permutation for the current stage length. It drives the 16 BRAM write ports (bank A: bram0..7, bank B: bram0B..7B) with an aligned address and write enable. It tracks the issue-to-result latency of the BU chain internally and pulses done at end of stage.

---
 rtl/bu_writeback.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/bu_writeback.sv
`default_nettype none
// ============================================================================
// Module   : bu_writeback
// Purpose  : Write-back router for the 8-butterfly NTT/iNTT datapath. Tracks
//            the issue-to-result latency of the BU chain with a delay line,
//            selects the NTT or iNTT results at the tail, undoes the read-side
//            BRAM-to-BU permutation for the stage length and drives both BRAM
//            banks with a registered address, data and write enable. Counts
//            write beats and pulses done_o on the last beat of a stage.
// Ports    : clk_i, rst_i (async, active-low)
//            issue_valid_i/issue_addr_i/len_i/is_NTT_i : read-beat issue info
//            a_ntt_i/b_ntt_i/a_intt_i/b_intt_i         : BU0..7 results
//            wr_en_o/wr_addr_o/wr_data_a_o/wr_data_b_o : BRAM write port
//            done_o    : one-cycle pulse with the last beat of a stage
//            len_err_o : sticky, an unsupported stage length was issued
// Revision : 1.0 - initial release
// ============================================================================
module bu_writeback #(
    parameter int DATA_WIDTH = 13,
    parameter int BU_LAT     = 4,
    parameter int ADDR_W     = 4,
    parameter int BEATS      = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        issue_valid_i,
    input  logic [ADDR_W-1:0]           issue_addr_i,
    input  logic [7:0]                  len_i,
    input  logic                        is_NTT_i,
    input  logic [8*(DATA_WIDTH-1)-1:0] a_ntt_i,
    input  logic [8*(DATA_WIDTH-1)-1:0] b_ntt_i,
    input  logic [8*(DATA_WIDTH-1)-1:0] a_intt_i,
    input  logic [8*(DATA_WIDTH-1)-1:0] b_intt_i,
    output logic                        wr_en_o,
    output logic [ADDR_W-1:0]           wr_addr_o,
    output logic [8*(DATA_WIDTH-1)-1:0] wr_data_a_o,
    output logic [8*(DATA_WIDTH-1)-1:0] wr_data_b_o,
    output logic                        done_o,
    output logic                        len_err_o
);

    localparam int CW    = DATA_WIDTH - 1;
    localparam int BUSW  = 8 * CW;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    // Routing modes decoded from the stage length
    localparam logic [1:0] MODE_128   = 2'd0;
    localparam logic [1:0] MODE_64    = 2'd1;
    localparam logic [1:0] MODE_32    = 2'd2;
    localparam logic [1:0] MODE_SMALL = 2'd3;

    // ------------------------------------------------------------------
    // Delay line: one entry per cycle of BU latency, tail at BU_LAT-1
    // ------------------------------------------------------------------
    logic [BU_LAT-1:0] dl_valid_q;
    logic [BU_LAT-1:0] dl_ntt_q;
    logic [ADDR_W-1:0] dl_addr_q [BU_LAT];
    logic [7:0]        dl_len_q  [BU_LAT];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            dl_valid_q <= '0;
            dl_ntt_q   <= '0;
            for (int i = 0; i < BU_LAT; i++) begin
                dl_addr_q[i] <= '0;
                dl_len_q[i]  <= '0;
            end
        end else begin
            dl_valid_q[0] <= issue_valid_i;
            dl_ntt_q[0]   <= is_NTT_i;
            dl_addr_q[0]  <= issue_addr_i;
            dl_len_q[0]   <= len_i;
            for (int i = 1; i < BU_LAT; i++) begin
                dl_valid_q[i] <= dl_valid_q[i-1];
                dl_ntt_q[i]   <= dl_ntt_q[i-1];
                dl_addr_q[i]  <= dl_addr_q[i-1];
                dl_len_q[i]   <= dl_len_q[i-1];
            end
        end
    end

    logic              w_t_valid;
    logic              w_t_ntt;
    logic [ADDR_W-1:0] w_t_addr;
    logic [7:0]        w_t_len;

    assign w_t_valid = dl_valid_q[BU_LAT-1];
    assign w_t_ntt   = dl_ntt_q[BU_LAT-1];
    assign w_t_addr  = dl_addr_q[BU_LAT-1];
    assign w_t_len   = dl_len_q[BU_LAT-1];

    // ------------------------------------------------------------------
    // Stage-length decode
    // ------------------------------------------------------------------
    logic [1:0] w_mode;
    logic       w_legal;

    always_comb begin
        w_mode  = MODE_SMALL;
        w_legal = 1'b1;
        case (w_t_len)
            8'd128:                    w_mode = MODE_128;
            8'd64:                     w_mode = MODE_64;
            8'd32:                     w_mode = MODE_32;
            8'd16, 8'd8, 8'd4, 8'd2:   w_mode = MODE_SMALL;
            default:                   w_legal = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Result selection and inverse permutation
    // ------------------------------------------------------------------
    logic [BUSW-1:0] w_a;
    logic [BUSW-1:0] w_b;

    assign w_a = w_t_ntt ? a_ntt_i : a_intt_i;
    assign w_b = w_t_ntt ? b_ntt_i : b_intt_i;

    function automatic logic [CW-1:0] slice(input logic [BUSW-1:0] v, input int k);
        return v[k*CW +: CW];
    endfunction

    logic [BUSW-1:0] w_route_a;
    logic [BUSW-1:0] w_route_b;

    // Each bank slot pair (2p, 2p+1) receives the A/B results of one BU.
    // Bank A takes BU "lo", bank B takes BU "hi" for pair p.
    always_comb begin
        w_route_a = '0;
        w_route_b = '0;
        for (int p = 0; p < 4; p++) begin
            case (w_mode)
                MODE_128: begin
                    w_route_a[(2*p)*CW +: CW]   = slice(w_a, p);
                    w_route_a[(2*p+1)*CW +: CW] = slice(w_b, p);
                    w_route_b[(2*p)*CW +: CW]   = slice(w_a, p + 4);
                    w_route_b[(2*p+1)*CW +: CW] = slice(w_b, p + 4);
                end
                MODE_64: begin
                    // lo BU = 0,1,4,5 ; hi BU = 2,3,6,7
                    w_route_a[(2*p)*CW +: CW]   = slice(w_a, p + 2*(p/2));
                    w_route_a[(2*p+1)*CW +: CW] = slice(w_b, p + 2*(p/2));
                    w_route_b[(2*p)*CW +: CW]   = slice(w_a, p + 2*(p/2) + 2);
                    w_route_b[(2*p+1)*CW +: CW] = slice(w_b, p + 2*(p/2) + 2);
                end
                default: begin
                    // len 32 and the short lengths share the even/odd split
                    w_route_a[(2*p)*CW +: CW]   = slice(w_a, 2*p);
                    w_route_a[(2*p+1)*CW +: CW] = slice(w_b, 2*p);
                    w_route_b[(2*p)*CW +: CW]   = slice(w_a, 2*p + 1);
                    w_route_b[(2*p+1)*CW +: CW] = slice(w_b, 2*p + 1);
                end
            endcase
        end
        // Short lengths: B0 and A1 trade places (A0 A1 in bank A, B0 B1 in bank B)
        if (w_mode == MODE_SMALL) begin
            w_route_a[1*CW +: CW] = slice(w_a, 1);
            w_route_b[0*CW +: CW] = slice(w_b, 0);
        end
    end

    // ------------------------------------------------------------------
    // Output register, beat counter, sticky error
    // ------------------------------------------------------------------
    logic              wr_en_q,   wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [BUSW-1:0]   data_a_q,  data_a_d;
    logic [BUSW-1:0]   data_b_q,  data_b_d;
    logic              done_q,    done_d;
    logic              len_err_q, len_err_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic              w_beat;

    assign w_beat = w_t_valid & w_legal;

    always_comb begin
        wr_en_d   = w_beat;
        wr_addr_d = wr_addr_q;
        data_a_d  = data_a_q;
        data_b_d  = data_b_q;
        done_d    = 1'b0;
        cnt_d     = cnt_q;
        len_err_d = len_err_q | (w_t_valid & ~w_legal);
        if (w_beat) begin
            wr_addr_d = w_t_addr;
            data_a_d  = w_route_a;
            data_b_d  = w_route_b;
            if (cnt_q == LAST_BEAT) begin
                done_d = 1'b1;
                cnt_d  = '0;
            end else begin
                cnt_d  = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            data_a_q  <= '0;
            data_b_q  <= '0;
            done_q    <= 1'b0;
            len_err_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            data_a_q  <= data_a_d;
            data_b_q  <= data_b_d;
            done_q    <= done_d;
            len_err_q <= len_err_d;
            cnt_q     <= cnt_d;
        end
    end

    assign wr_en_o     = wr_en_q;
    assign wr_addr_o   = wr_addr_q;
    assign wr_data_a_o = data_a_q;
    assign wr_data_b_o = data_b_q;
    assign done_o      = done_q;
    assign len_err_o   = len_err_q;

endmodule
`default_nettype wire
